// File: rtl/microwave_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : microwave_timer_ctrl
// Brief   : Keypad/door sequencer driving a min:sec-tens:sec-units countdown
//           chain (load, clear, 1 Hz enable) with pause and end-of-cook beep.
// Revision: 1.0  initial release
// ============================================================================
module microwave_timer_ctrl #(
    parameter int BEEP_TICKS = 3,
    parameter int TENS_MAX   = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       keypad_valid,
    input  logic [3:0] keypad_digit,
    input  logic       start,
    input  logic       stop_clear,
    input  logic       door_closed,
    input  logic       count_zero,
    output logic [3:0] data_min,
    output logic [3:0] data_sec_t,
    output logic [3:0] data_sec_u,
    output logic       loadn,
    output logic       clearn,
    output logic       enable,
    output logic       magnetron_on,
    output logic       beep,
    output logic       entry_err
);

    localparam int             c_BCW       = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS) : 1;
    localparam logic [c_BCW-1:0] c_BEEP_LAST = c_BCW'(BEEP_TICKS - 1);
    localparam logic [3:0]     c_TENS_MAX  = 4'(TENS_MAX);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENTRY = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_PAUSE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [3:0]         r_min;
    logic [3:0]         r_sec_t;
    logic [3:0]         r_sec_u;
    logic               r_loadn;
    logic               r_clearn;
    logic               r_entry_err;
    logic [c_BCW-1:0]   r_beep_cnt;

    logic               w_digit_ok;
    logic               w_buf_nz;
    logic               w_tens_bad;
    logic               w_buf_clr;
    logic               w_buf_shift;
    logic               w_clr_pulse;
    logic               w_err;
    logic               w_beep_inc;

    assign w_digit_ok = keypad_valid && (keypad_digit <= 4'd9);
    assign w_buf_nz   = |{r_min, r_sec_t, r_sec_u};
    assign w_tens_bad = (r_sec_t > c_TENS_MAX);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_buf_clr   = 1'b0;
        w_buf_shift = 1'b0;
        w_clr_pulse = 1'b0;
        w_err       = 1'b0;
        w_beep_inc  = 1'b0;
        case (r_state)
            S_IDLE, S_ENTRY: begin
                if (stop_clear) begin
                    w_buf_clr   = 1'b1;
                    w_clr_pulse = 1'b1;
                    w_next      = S_IDLE;
                end else if (start && door_closed && w_buf_nz && !w_tens_bad) begin
                    w_next = S_LOAD;
                end else if (start && door_closed && w_tens_bad) begin
                    w_err = 1'b1;
                end else if (w_digit_ok) begin
                    w_buf_shift = 1'b1;
                    w_next      = S_ENTRY;
                end
            end
            S_LOAD: begin
                w_next = S_RUN;
            end
            S_RUN: begin
                // count_zero outranks an open door so a finished cook ends in DONE
                if (stop_clear) begin
                    w_next = S_PAUSE;
                end else if (count_zero) begin
                    w_next = S_DONE;
                end else if (!door_closed) begin
                    w_next = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (stop_clear) begin
                    w_buf_clr   = 1'b1;
                    w_clr_pulse = 1'b1;
                    w_next      = S_IDLE;
                end else if (start && door_closed) begin
                    w_next = S_RUN;
                end
            end
            S_DONE: begin
                if (stop_clear) begin
                    w_buf_clr = 1'b1;
                    w_next    = S_IDLE;
                end else if (tick_1hz) begin
                    if (r_beep_cnt == c_BEEP_LAST) begin
                        w_buf_clr = 1'b1;
                        w_next    = S_IDLE;
                    end else begin
                        w_beep_inc = 1'b1;
                    end
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_min       <= 4'd0;
            r_sec_t     <= 4'd0;
            r_sec_u     <= 4'd0;
            r_loadn     <= 1'b1;
            r_clearn    <= 1'b0;
            r_entry_err <= 1'b0;
            r_beep_cnt  <= '0;
        end else begin
            // loadn is low exactly while the FSM sits in LOAD
            r_loadn     <= (w_next != S_LOAD);
            r_clearn    <= !w_clr_pulse;
            r_entry_err <= w_err;
            if (w_buf_clr) begin
                r_min   <= 4'd0;
                r_sec_t <= 4'd0;
                r_sec_u <= 4'd0;
            end else if (w_buf_shift) begin
                r_min   <= r_sec_t;
                r_sec_t <= r_sec_u;
                r_sec_u <= keypad_digit;
            end
            if (r_state != S_DONE) begin
                r_beep_cnt <= '0;
            end else if (w_beep_inc) begin
                r_beep_cnt <= r_beep_cnt + 1'b1;
            end
        end
    end

    assign data_min     = r_min;
    assign data_sec_t   = r_sec_t;
    assign data_sec_u   = r_sec_u;
    assign loadn        = r_loadn;
    assign clearn       = r_clearn;
    assign entry_err    = r_entry_err;
    assign magnetron_on = (r_state == S_RUN);
    assign beep         = (r_state == S_DONE);
    // Every RUN exit condition gates enable in the same cycle it is seen
    assign enable       = (r_state == S_RUN) && tick_1hz && !count_zero && door_closed
                          && !stop_clear && !reset;

endmodule
`default_nettype wire

// File: tb/tb_microwave_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_microwave_timer_ctrl
// Brief   : Self-checking bench: directed vector table, corner-case sequences
//           and random stimulus against a decimal-arithmetic reference model.
// Revision: 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_microwave_timer_ctrl;

    localparam int BEEP_TICKS = 3;
    localparam int TENS_MAX   = 5;

    localparam int M_IDLE  = 0;
    localparam int M_ENTRY = 1;
    localparam int M_LOAD  = 2;
    localparam int M_RUN   = 3;
    localparam int M_PAUSE = 4;
    localparam int M_DONE  = 5;

    logic       clock = 1'b0;
    logic       reset, tick_1hz, keypad_valid, start, stop_clear, door_closed, count_zero;
    logic [3:0] keypad_digit;
    logic [3:0] data_min, data_sec_t, data_sec_u;
    logic       loadn, clearn, enable, magnetron_on, beep, entry_err;

    always #5 clock = ~clock;

    microwave_timer_ctrl #(.BEEP_TICKS(BEEP_TICKS), .TENS_MAX(TENS_MAX)) dut (
        .clock(clock), .reset(reset), .tick_1hz(tick_1hz), .keypad_valid(keypad_valid),
        .keypad_digit(keypad_digit), .start(start), .stop_clear(stop_clear),
        .door_closed(door_closed), .count_zero(count_zero), .data_min(data_min),
        .data_sec_t(data_sec_t), .data_sec_u(data_sec_u), .loadn(loadn), .clearn(clearn),
        .enable(enable), .magnetron_on(magnetron_on), .beep(beep), .entry_err(entry_err)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc_no   = 0;

    // Reference model: buffer is the 3-digit decimal number shown on the display
    int   m_mode, m_buf, m_beeps;
    logic m_loadn, m_clearn, m_err;
    int   env_secs;

    logic s_ld, s_cl, s_en, s_mg, s_bp, s_er;
    logic [11:0] s_data;

    typedef struct {
        logic rst, tk, kv; logic [3:0] kd; logic st, sc, dc, cz;
        logic ld, cl, en, mg, bp, er; logic [11:0] d;
    } vec_t;

    vec_t tbl [26];

    function automatic vec_t mk(input logic rst, tk, kv, input logic [3:0] kd,
                                input logic st, sc, dc, cz,
                                input logic ld, cl, en, mg, bp, er, input logic [11:0] d);
        vec_t v;
        v.rst = rst; v.tk = tk; v.kv = kv; v.kd = kd; v.st = st; v.sc = sc; v.dc = dc; v.cz = cz;
        v.ld = ld; v.cl = cl; v.en = en; v.mg = mg; v.bp = bp; v.er = er; v.d = d;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc_no, act, exp);
    endtask

    function automatic logic [17:0] m_out(input logic rst, tk, sc, dc, cz);
        logic en;
        en = (m_mode == M_RUN) && tk && !cz && dc && !sc && !rst;
        return {m_loadn, m_clearn, en, (m_mode == M_RUN), (m_mode == M_DONE), m_err,
                4'(m_buf / 100), 4'((m_buf / 10) % 10), 4'(m_buf % 10)};
    endfunction

    task automatic m_reset();
        m_mode = M_IDLE; m_buf = 0; m_beeps = 0;
        m_loadn = 1'b1; m_clearn = 1'b0; m_err = 1'b0;
    endtask

    task automatic m_step(input logic rst, tk, kv, input logic [3:0] kd, input logic st, sc, dc, cz);
        int tens;
        tens = (m_buf / 10) % 10;
        if (rst) begin
            m_reset();
            return;
        end
        m_loadn = 1'b1; m_clearn = 1'b1; m_err = 1'b0;
        case (m_mode)
            M_IDLE, M_ENTRY: begin
                if (sc) begin
                    m_buf = 0; m_clearn = 1'b0; m_mode = M_IDLE;
                end else if (st && dc && m_buf != 0 && tens <= TENS_MAX) begin
                    m_mode = M_LOAD; m_loadn = 1'b0;
                end else if (st && dc && tens > TENS_MAX) begin
                    m_err = 1'b1;
                end else if (kv && kd <= 9) begin
                    m_buf = (m_buf * 10 + int'(kd)) % 1000; m_mode = M_ENTRY;
                end
            end
            M_LOAD: m_mode = M_RUN;
            M_RUN: begin
                if (sc) m_mode = M_PAUSE;
                else if (cz) begin m_mode = M_DONE; m_beeps = 0; end
                else if (!dc) m_mode = M_PAUSE;
            end
            M_PAUSE: begin
                if (sc) begin m_mode = M_IDLE; m_buf = 0; m_clearn = 1'b0; end
                else if (st && dc) m_mode = M_RUN;
            end
            M_DONE: begin
                if (sc) begin m_mode = M_IDLE; m_buf = 0; end
                else if (tk) begin
                    m_beeps++;
                    if (m_beeps == BEEP_TICKS) begin m_mode = M_IDLE; m_buf = 0; end
                end
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    // One clock: drive at negedge, sample/check, advance model and counter environment
    task automatic cyc(input logic rst, tk, kv, input logic [3:0] kd, input logic st, sc, dc, cz);
        reset = rst; tick_1hz = tk; keypad_valid = kv; keypad_digit = kd;
        start = st; stop_clear = sc; door_closed = dc; count_zero = cz;
        #1;
        s_ld = loadn; s_cl = clearn; s_en = enable; s_mg = magnetron_on;
        s_bp = beep; s_er = entry_err; s_data = {data_min, data_sec_t, data_sec_u};
        check("model", {s_ld, s_cl, s_en, s_mg, s_bp, s_er, s_data}, m_out(rst, tk, sc, dc, cz));
        m_step(rst, tk, kv, kd, st, sc, dc, cz);
        if (!s_cl) env_secs = 0;
        else if (!s_ld) env_secs = int'(s_data[11:8]) * 60 + int'(s_data[7:4]) * 10 + int'(s_data[3:0]);
        else if (s_en && env_secs > 0) env_secs--;
        @(posedge clock);
        @(negedge clock);
        cyc_no++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 4'd0, 0, 0, 1, 0);
    endtask

    task automatic key(input logic [3:0] d);
        cyc(0, 0, 1, d, 0, 0, 1, 0);
    endtask

    initial begin
        logic dr;
        reset = 1; tick_1hz = 0; keypad_valid = 0; keypad_digit = 0;
        start = 0; stop_clear = 0; door_closed = 1; count_zero = 0;
        env_secs = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        m_reset();

        //            rst tk kv kd  st sc dc cz   ld cl en mg bp er data
        tbl[0]  = mk(1, 0, 0, 4'd0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 12'h000);
        tbl[1]  = mk(0, 0, 0, 4'd0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 12'h000);
        tbl[2]  = mk(0, 0, 1, 4'd1, 0, 0, 1, 0,  1, 1, 0, 0, 0, 0, 12'h000);
        tbl[3]  = mk(0, 0, 1, 4'd3, 0, 0, 1, 0,  1, 1, 0, 0, 0, 0, 12'h001);
        tbl[4]  = mk(0, 0, 1, 4'd0, 0, 0, 1, 0,  1, 1, 0, 0, 0, 0, 12'h013);
        tbl[5]  = mk(0, 0, 1, 4'd12,0, 0, 1, 0,  1, 1, 0, 0, 0, 0, 12'h130);
        tbl[6]  = mk(0, 0, 0, 4'd0, 1, 0, 1, 0,  1, 1, 0, 0, 0, 0, 12'h130);
        tbl[7]  = mk(0, 0, 0, 4'd0, 0, 0, 1, 0,  0, 1, 0, 0, 0, 0, 12'h130);
        tbl[8]  = mk(0, 1, 0, 4'd0, 0, 0, 1, 0,  1, 1, 1, 1, 0, 0, 12'h130);
        tbl[9]  = mk(0, 0, 0, 4'd0, 0, 0, 1, 0,  1, 1, 0, 1, 0, 0, 12'h130);
        tbl[10] = mk(0, 1, 1, 4'd5, 0, 0, 1, 0,  1, 1, 1, 1, 0, 0, 12'h130);
        tbl[11] = mk(0, 1, 0, 4'd0, 0, 0, 1, 1,  1, 1, 0, 1, 0, 0, 12'h130);
        tbl[12] = mk(0, 1, 0, 4'd0, 0, 0, 1, 1,  1, 1, 0, 0, 1, 0, 12'h130);
        tbl[13] = mk(0, 0, 0, 4'd0, 0, 0, 1, 1,  1, 1, 0, 0, 1, 0, 12'h130);
        tbl[14] = mk(0, 1, 0, 4'd0, 0, 0, 1, 1,  1, 1, 0, 0, 1, 0, 12'h130);
        tbl[15] = mk(0, 1, 0, 4'd0, 0, 0, 1, 1,  1, 1, 0, 0, 1, 0, 12'h130);
        tbl[16] = mk(0, 0, 0, 4'd0, 0, 0, 1, 0,  1, 1, 0, 0, 0, 0, 12'h000);
        tbl[17] = mk(0, 0, 1, 4'd0, 0, 0, 1, 0,  1, 1, 0, 0, 0, 0, 12'h000);
        tbl[18] = mk(0, 0, 1, 4'd7, 0, 0, 1, 0,  1, 1, 0, 0, 0, 0, 12'h000);
        tbl[19] = mk(0, 0, 1, 4'd5, 0, 0, 1, 0,  1, 1, 0, 0, 0, 0, 12'h007);
        tbl[20] = mk(0, 0, 0, 4'd0, 1, 0, 1, 0,  1, 1, 0, 0, 0, 0, 12'h075);
        tbl[21] = mk(0, 0, 0, 4'd0, 0, 0, 1, 0,  1, 1, 0, 0, 0, 1, 12'h075);
        tbl[22] = mk(0, 0, 0, 4'd0, 0, 0, 1, 0,  1, 1, 0, 0, 0, 0, 12'h075);
        tbl[23] = mk(0, 0, 0, 4'd0, 0, 1, 1, 0,  1, 1, 0, 0, 0, 0, 12'h075);
        tbl[24] = mk(0, 0, 0, 4'd0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 12'h000);
        tbl[25] = mk(0, 0, 0, 4'd0, 0, 0, 1, 0,  1, 1, 0, 0, 0, 0, 12'h000);

        for (int i = 0; i < 26; i++) begin
            cyc(tbl[i].rst, tbl[i].tk, tbl[i].kv, tbl[i].kd, tbl[i].st, tbl[i].sc, tbl[i].dc, tbl[i].cz);
            check($sformatf("vec%0d", i), {s_ld, s_cl, s_en, s_mg, s_bp, s_er, s_data},
                  {tbl[i].ld, tbl[i].cl, tbl[i].en, tbl[i].mg, tbl[i].bp, tbl[i].er, tbl[i].d});
        end

        // Door opens in RUN, then resume without a reload
        key(4'd2);
        cyc(0, 0, 0, 4'd0, 1, 0, 1, 0);
        idle(1);
        cyc(0, 1, 0, 4'd0, 0, 0, 1, 0);
        check("run_en", 32'(s_en), 32'd1);
        cyc(0, 1, 0, 4'd0, 0, 0, 0, 0);
        check("door_en", 32'(s_en), 32'd0);
        cyc(0, 1, 0, 4'd0, 0, 0, 0, 0);
        check("pause_mag", 32'(s_mg), 32'd0);
        check("pause_en", 32'(s_en), 32'd0);
        cyc(0, 0, 0, 4'd0, 1, 0, 1, 0);
        cyc(0, 0, 0, 4'd0, 0, 0, 1, 0);
        check("resume_mag", 32'(s_mg), 32'd1);
        check("resume_noload", 32'(s_ld), 32'd1);

        // Stop pauses, second stop clears
        cyc(0, 0, 0, 4'd0, 0, 1, 1, 0);
        cyc(0, 0, 0, 4'd0, 0, 1, 1, 0);
        check("stop_pause_mag", 32'(s_mg), 32'd0);
        idle(1);
        check("stop_clearn", 32'(s_cl), 32'd0);
        check("stop_buf", 32'(s_data), 32'd0);
        idle(1);
        check("stop_clearn_rel", 32'(s_cl), 32'd1);

        // Reset in RUN
        key(4'd4);
        cyc(0, 0, 0, 4'd0, 1, 0, 1, 0);
        idle(1);
        cyc(1, 1, 0, 4'd0, 0, 0, 1, 0);
        check("rst_en", 32'(s_en), 32'd0);
        idle(1);
        check("rst_clearn", 32'(s_cl), 32'd0);
        check("rst_mag", 32'(s_mg), 32'd0);
        idle(1);

        // count_zero with door open in the same cycle goes to DONE
        key(4'd9);
        cyc(0, 0, 0, 4'd0, 1, 0, 1, 0);
        idle(1);
        cyc(0, 0, 0, 4'd0, 0, 0, 0, 1);
        cyc(0, 0, 0, 4'd0, 0, 0, 0, 1);
        check("cz_door_beep", 32'(s_bp), 32'd1);
        cyc(0, 0, 0, 4'd0, 0, 1, 1, 1);
        idle(1);
        check("done_stop_beep", 32'(s_bp), 32'd0);

        // Start ignored with empty buffer or open door
        cyc(0, 0, 0, 4'd0, 1, 0, 1, 0);
        idle(1);
        check("empty_start_ld", 32'(s_ld), 32'd1);
        key(4'd1);
        cyc(0, 0, 0, 4'd0, 1, 0, 0, 0);
        idle(1);
        check("door_start_ld", 32'(s_ld), 32'd1);
        check("door_start_err", 32'(s_er), 32'd0);
        cyc(0, 0, 0, 4'd0, 0, 1, 1, 0);
        idle(2);

        // Random stimulus against the reference model
        dr = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 39) == 0) dr = ~dr;
            cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 11)),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 63) == 0), dr,
                (env_secs == 0) || ($urandom_range(0, 63) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
